// File: rtl/tinyalu_core.sv
// TinyALU responder core: start/done handshake, single-cycle add/and/xor
// and a MUL_LATENCY-deep staged multiply, one operation in flight.
module tinyalu_core #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    MUL
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic [15:0] p_q [MUL_LATENCY];
  logic [15:0] p_d [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] v_q, v_d;

  logic        is_single;
  logic        is_mul;
  logic [15:0] alu;

  assign is_single = start && (op == 3'd1 || op == 3'd2 || op == 3'd3);
  assign is_mul    = start && (op == 3'd4);

  always_comb begin
    alu = 16'h0000;
    case (op_q)
      3'd1:    alu = 16'(a_q) + 16'(b_q);
      3'd2:    alu = {8'h00, a_q & b_q};
      3'd3:    alu = {8'h00, a_q ^ b_q};
      default: alu = 16'h0000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    // Product and its valid bit advance one stage per edge.
    p_d[0]   = p_q[0];
    v_d[0]   = 1'b0;
    for (int i = 1; i < int'(MUL_LATENCY); i++) begin
      p_d[i] = p_q[i-1];
      v_d[i] = v_q[i-1];
    end
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          is_single: begin
            a_d     = A;
            b_d     = B;
            op_d    = op;
            state_d = SINGLE;
          end
          is_mul: begin
            a_d     = A;
            b_d     = B;
            op_d    = op;
            cnt_d   = CNT_INIT;
            p_d[0]  = 16'(A) * 16'(B);
            v_d[0]  = 1'b1;
            state_d = MUL;
          end
          default: ;
        endcase
      end
      SINGLE: begin
        done_d   = 1'b1;
        result_d = alu;
        state_d  = IDLE;
      end
      MUL: begin
        if (cnt_q == 3'd0 && v_q[MUL_LATENCY-1]) begin
          done_d   = 1'b1;
          result_d = p_q[MUL_LATENCY-1];
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'd0;
      cnt_q    <= 3'd0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      v_q      <= '0;
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        p_q[i] <= 16'h0000;
      end
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      v_q      <= v_d;
      p_q      <= p_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
